// File: rtl/uart_fromhost_rx.sv
// Host-to-core UART receiver: 8N1, LSB first, four bytes assembled into a
// little-endian 32-bit word offered to the core over a valid/ready handshake.
module uart_fromhost_rx #(
  parameter int unsigned CLK_HZ = 25000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  output logic [31:0] FROMHOST,
  output logic        FROMHOST_VALID,
  input  logic        FROMHOST_READY,
  output logic        FRAME_ERR,
  output logic        OVERRUN
);

  localparam int unsigned N  = CLK_HZ / BAUD;
  localparam int unsigned H  = N / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] N_M1 = CW'(N - 1);
  localparam logic [CW-1:0] H_M1 = CW'(H - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  if (N < 4) begin : g_n_check
    $error("uart_fromhost_rx: CLK_HZ/BAUD must be at least 4");
  end

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    k_q, k_d;
  logic [31:0]   stage_q, stage_d;
  logic [31:0]   out_q, out_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          byte_ok;
  logic          accept;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM: byte_ok flags a good stop bit with the byte still in shift_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    byte_ok   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == H_M1) begin
          if (!rx_s_q) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == N_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == N_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word assembler and output slot; a load may coincide with an accept.
  always_comb begin
    k_d     = k_q;
    stage_d = stage_q;
    out_d   = out_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    accept  = valid_q & FROMHOST_READY;
    if (accept) valid_d = 1'b0;
    if (ferr_d) k_d = '0;
    if (byte_ok) begin
      case (k_q)
        2'd0:    stage_d[7:0]   = shift_q;
        2'd1:    stage_d[15:8]  = shift_q;
        2'd2:    stage_d[23:16] = shift_q;
        default: stage_d[31:24] = shift_q;
      endcase
      k_d = k_q + 2'd1;
      if (k_q == 2'd3) begin
        if (!valid_q || accept) begin
          out_d   = {shift_q, stage_q[23:0]};
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      k_q       <= '0;
      stage_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      k_q       <= k_d;
      stage_q   <= stage_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign FROMHOST       = out_q;
  assign FROMHOST_VALID = valid_q;
  assign FRAME_ERR      = ferr_q;
  assign OVERRUN        = ovr_q;

endmodule

// File: tb/tb_uart_fromhost_rx.sv
// Directed bench for uart_fromhost_rx at N=16 clocks per bit.
module tb_uart_fromhost_rx;

  localparam int unsigned N = 16;
  localparam int unsigned H = N / 2;
  // RXD edge to first IDLE cycle with rx_s low is 2 synchronizer cycles.
  localparam int unsigned LAT = 2 + H + 9 * N + 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RXD;
  logic [31:0] FROMHOST;
  logic        FROMHOST_VALID;
  logic        FROMHOST_READY;
  logic        FRAME_ERR;
  logic        OVERRUN;

  uart_fromhost_rx #(.CLK_HZ(160), .BAUD(10)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD),
    .FROMHOST(FROMHOST), .FROMHOST_VALID(FROMHOST_VALID),
    .FROMHOST_READY(FROMHOST_READY),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          valid_hi = 0, fe_cnt = 0, ov_cnt = 0, falls = 0, rise_cyc = 0;
  logic [31:0] last_word = '0;
  logic        prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (FROMHOST_VALID) begin
      valid_hi++;
      last_word = FROMHOST;
      if (!prev_valid) rise_cyc = cyc;
    end
    if (prev_valid && !FROMHOST_VALID) falls++;
    if (FRAME_ERR) fe_cnt++;
    if (OVERRUN) ov_cnt++;
    prev_valid = FROMHOST_VALID;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int last_start = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    last_start = cyc;
    repeat (N) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (N) @(negedge CLK);
    end
    RXD = stop;
    repeat (N) @(negedge CLK);
    RXD = 1'b1;
  endtask

  int start3 = 0;
  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
    start3 = cyc;
    send_byte(w[31:24], 1'b1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_word;
    int          exp_hi;
    int          exp_lat;
  } vec_t;
  vec_t vecs[5];

  int b_hi, b_fe, b_ov, b_falls;

  initial begin
    vecs[0] = '{32'h12345678, 32'h12345678, 1, LAT};
    vecs[1] = '{32'h00000000, 32'h00000000, 1, LAT};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1, LAT};
    vecs[3] = '{32'hA5A55A5A, 32'hA5A55A5A, 1, LAT};
    vecs[4] = '{32'h80000001, 32'h80000001, 1, LAT};

    RST = 1'b1;
    RXD = 1'b1;
    FROMHOST_READY = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_word", FROMHOST, 32'h0);
    check("rst_valid", {31'b0, FROMHOST_VALID}, 32'h0);
    check("rst_ferr", {31'b0, FRAME_ERR}, 32'h0);
    check("rst_ovr", {31'b0, OVERRUN}, 32'h0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Normal words, always ready
    FROMHOST_READY = 1'b1;
    for (int v = 0; v < 5; v++) begin
      b_hi = valid_hi; b_fe = fe_cnt; b_ov = ov_cnt;
      send_word(vecs[v].word);
      repeat (4) @(negedge CLK);
      check($sformatf("vec%0d_word", v), last_word, vecs[v].exp_word);
      check($sformatf("vec%0d_valid_cycles", v), 32'(valid_hi - b_hi), 32'(vecs[v].exp_hi));
      check($sformatf("vec%0d_latency", v), 32'(rise_cyc - start3), 32'(vecs[v].exp_lat));
      check($sformatf("vec%0d_ferr", v), 32'(fe_cnt - b_fe), 32'h0);
      check($sformatf("vec%0d_ovr", v), 32'(ov_cnt - b_ov), 32'h0);
    end

    // Overrun: second word dropped while first is held
    FROMHOST_READY = 1'b0;
    b_ov = ov_cnt;
    send_word(32'hDEADBEEF);
    send_word(32'h01020304);
    repeat (4) @(negedge CLK);
    check("ovr_pulses", 32'(ov_cnt - b_ov), 32'h1);
    check("ovr_word", FROMHOST, 32'hDEADBEEF);
    check("ovr_valid_held", {31'b0, FROMHOST_VALID}, 32'h1);
    FROMHOST_READY = 1'b1;
    @(negedge CLK);
    check("ovr_valid_drop", {31'b0, FROMHOST_VALID}, 32'h0);
    check("ovr_word_kept", FROMHOST, 32'hDEADBEEF);

    // Framing error discards the partial word
    b_hi = valid_hi; b_fe = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (2 * N) @(negedge CLK);
    check("fe_pulses", 32'(fe_cnt - b_fe), 32'h1);
    send_word(32'hAABBCCDD);
    repeat (4) @(negedge CLK);
    check("fe_word", last_word, 32'hAABBCCDD);
    check("fe_valid_cycles", 32'(valid_hi - b_hi), 32'h1);
    check("fe_pulses_after", 32'(fe_cnt - b_fe), 32'h1);

    // Glitch on the line
    b_hi = valid_hi; b_fe = fe_cnt;
    RXD = 1'b0;
    repeat (4) @(negedge CLK);
    RXD = 1'b1;
    repeat (3 * N) @(negedge CLK);
    check("glitch_no_valid", 32'(valid_hi - b_hi), 32'h0);
    check("glitch_no_ferr", 32'(fe_cnt - b_fe), 32'h0);
    send_word(32'h5EC0DE42);
    repeat (4) @(negedge CLK);
    check("glitch_next_word", last_word, 32'h5EC0DE42);
    check("glitch_next_cycles", 32'(valid_hi - b_hi), 32'h1);

    // Accept and load in the same cycle
    FROMHOST_READY = 1'b0;
    send_word(32'h11223344);
    repeat (4) @(negedge CLK);
    check("sim_a_held", FROMHOST, 32'h11223344);
    b_ov = ov_cnt; b_falls = falls;
    send_byte(8'h0D, 1'b1);
    send_byte(8'hC0, 1'b1);
    send_byte(8'hFE, 1'b1);
    fork
      send_byte(8'hCA, 1'b1);
      begin
        repeat (LAT - 1) @(negedge CLK);
        FROMHOST_READY = 1'b1;
        @(negedge CLK);
        FROMHOST_READY = 1'b0;
        check("sim_b_word", FROMHOST, 32'hCAFEC00D);
        check("sim_b_valid", {31'b0, FROMHOST_VALID}, 32'h1);
      end
    join
    repeat (4) @(negedge CLK);
    check("sim_no_ovr", 32'(ov_cnt - b_ov), 32'h0);
    check("sim_no_drop", 32'(falls - b_falls), 32'h0);
    check("sim_b_hold", FROMHOST, 32'hCAFEC00D);

    // Reset during bit 3 of byte 2 while a word is held
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    RXD = 1'b0;
    repeat (N) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RXD = 1'b1;
      repeat (N) @(negedge CLK);
    end
    RXD = 1'b0;
    repeat (N / 2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_word", FROMHOST, 32'h0);
    check("mid_rst_valid", {31'b0, FROMHOST_VALID}, 32'h0);
    check("mid_rst_ferr", {31'b0, FRAME_ERR}, 32'h0);
    check("mid_rst_ovr", {31'b0, OVERRUN}, 32'h0);
    @(negedge CLK);
    RXD = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    FROMHOST_READY = 1'b1;
    b_hi = valid_hi; b_fe = fe_cnt; b_ov = ov_cnt;
    send_word(32'hCAFEF00D);
    repeat (4) @(negedge CLK);
    check("post_rst_word", last_word, 32'hCAFEF00D);
    check("post_rst_cycles", 32'(valid_hi - b_hi), 32'h1);
    check("post_rst_latency", 32'(rise_cyc - start3), 32'(LAT));
    check("post_rst_errs", 32'((fe_cnt - b_fe) + (ov_cnt - b_ov)), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
